// File: rtl/fetch_decode_buffer.sv
// Two-entry in-order buffer between fetch and decode. Each instruction is
// decoded for immediate selection on entry, so the head outputs are pure registers.
module fetch_decode_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_opcode,
  output logic [10:0] out_instr,
  output logic [2:0]  out_ImmOp,
  output logic        out_uses_imm,
  output logic [15:0] out_pc
);

  logic [1:0][15:0] instr_q;
  logic [1:0][15:0] pc_q;
  logic [1:0][2:0]  immop_q;
  logic [1:0]       uses_imm_q;
  logic [1:0]       count_q;
  logic [1:0]       count_next;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic             in_ready_q;

  logic             push;
  logic             pop;
  logic [2:0]       dec_immop;
  logic             dec_uses_imm;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high and flush is low; flush overrides both directions.
  assign push = in_valid & in_ready_q & ~flush & (count_q != 2'd2);
  assign pop  = out_valid & out_ready & ~flush;

  // Immediate-select decode on opcode[4:2].
  always_comb begin
    dec_immop    = 3'b000;
    dec_uses_imm = 1'b0;
    case (in_instr[15:13])
      3'b000, 3'b001: begin
        dec_immop    = 3'b000;
        dec_uses_imm = 1'b0;
      end
      3'b010: begin
        dec_immop    = 3'b000;
        dec_uses_imm = 1'b1;
      end
      3'b011: begin
        dec_immop    = 3'b010;
        dec_uses_imm = 1'b1;
      end
      3'b100: begin
        dec_immop    = 3'b011;
        dec_uses_imm = 1'b1;
      end
      3'b101: begin
        dec_immop    = 3'b101;
        dec_uses_imm = 1'b1;
      end
      default: begin
        dec_immop    = 3'b001;
        dec_uses_imm = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + 2'd1;
      2'b01:   count_next = count_q - 2'd1;
      default: count_next = count_q;
    endcase
    if (flush) begin
      count_next = 2'd0;
    end
  end

  // in_ready is registered so it reads 0 throughout reset and only rises on
  // the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      pc_q       <= '0;
      immop_q    <= '0;
      uses_imm_q <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      count_q    <= count_next;
      in_ready_q <= (count_next != 2'd2);
      if (flush) begin
        instr_q    <= '0;
        pc_q       <= '0;
        immop_q    <= '0;
        uses_imm_q <= '0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
      end else begin
        if (push) begin
          instr_q[wr_ptr_q]    <= in_instr;
          pc_q[wr_ptr_q]       <= in_pc;
          immop_q[wr_ptr_q]    <= dec_immop;
          uses_imm_q[wr_ptr_q] <= dec_uses_imm;
          wr_ptr_q             <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (count_q != 2'd0);
  assign out_opcode   = instr_q[rd_ptr_q][15:11];
  assign out_instr    = instr_q[rd_ptr_q][10:0];
  assign out_ImmOp    = immop_q[rd_ptr_q];
  assign out_uses_imm = uses_imm_q[rd_ptr_q];
  assign out_pc       = pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: directed scenarios plus random traffic, all
// checked against a queue-based model of a 2-deep FIFO with an opcode-range decode table.
module tb_fetch_decode_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opcode;
  logic [10:0] out_instr;
  logic [2:0]  out_ImmOp;
  logic        out_uses_imm;
  logic [15:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [15:0] popped_pcs[$];
  logic        record_pops = 1'b0;
  logic        seen_edge;

  fetch_decode_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_instr    (out_instr),
    .out_ImmOp    (out_ImmOp),
    .out_uses_imm (out_uses_imm),
    .out_pc       (out_pc)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) seen_edge <= 1'b0;
    else     seen_edge <= 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written as opcode value ranges: returns {ImmOp, uses_imm}.
  function automatic logic [3:0] ref_dec(input logic [15:0] instr);
    int op;
    op = int'(instr[15:11]);
    if (op < 8)       return 4'b000_0;
    else if (op < 12) return 4'b000_1;
    else if (op < 16) return 4'b010_1;
    else if (op < 20) return 4'b011_1;
    else if (op < 24) return 4'b101_1;
    else              return 4'b001_1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_instr  = 16'h0;
    in_pc     = 16'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Samples mid-cycle, compares the head against the model, then applies the
  // transfers the coming edge will perform to the model queue.
  always @(negedge clk) begin
    logic exp_ready;
    logic [31:0] e;
    if (rst) begin
      check("rst_valid_ready", {46'h0, out_valid, in_ready}, 48'h0);
      check("rst_outputs", {12'h0, out_opcode, out_instr, out_ImmOp, out_uses_imm, out_pc}, 48'h0);
      exp_q.delete();
    end else begin
      exp_ready = seen_edge && (exp_q.size() != 2);
      check("in_ready", {47'h0, in_ready}, {47'h0, exp_ready});
      check("out_valid", {47'h0, out_valid}, {47'h0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("head_instr", {32'h0, out_opcode, out_instr}, {32'h0, e[31:16]});
        check("head_decode", {44'h0, out_ImmOp, out_uses_imm}, {44'h0, ref_dec(e[31:16])});
        check("head_pc", {32'h0, out_pc}, {32'h0, e[15:0]});
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && out_ready) begin
          if (record_pops) popped_pcs.push_back(out_pc);
          void'(exp_q.pop_front());
        end
        if (in_valid && exp_ready) exp_q.push_back({in_instr, in_pc});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit done;
    bit acc;
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    check("reset_in_ready", {47'h0, in_ready}, 48'h0);
    check("reset_out_valid", {47'h0, out_valid}, 48'h0);
    rst = 1'b0;
    step();

    // First instruction into an empty buffer, held at the head.
    in_valid = 1'b1; in_instr = 16'h5A85; in_pc = 16'h0010;
    step();
    in_valid = 1'b0;
    check("first_valid", {47'h0, out_valid}, 48'h1);
    check("first_opcode", {43'h0, out_opcode}, {43'h0, 5'b01011});
    check("first_instr", {37'h0, out_instr}, {37'h0, 11'h285});
    check("first_decode", {44'h0, out_ImmOp, out_uses_imm}, {44'h0, 4'b000_1});
    check("first_pc", {32'h0, out_pc}, {32'h0, 16'h0010});
    step();
    check("first_held_pc", {32'h0, out_pc}, {32'h0, 16'h0010});
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Fill to two entries; a third offer must be refused.
    in_valid = 1'b1; in_instr = 16'h6003; in_pc = 16'h0020;
    step();
    in_instr = 16'hA1FF; in_pc = 16'h0022;
    step();
    check("full_in_ready", {47'h0, in_ready}, 48'h0);
    in_instr = 16'h1234; in_pc = 16'h0024;
    step();
    in_valid = 1'b0;
    check("full_head_immop", {45'h0, out_ImmOp}, {45'h0, 3'b010});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("second_head_immop", {45'h0, out_ImmOp}, {45'h0, 3'b101});
    check("second_head_pc", {32'h0, out_pc}, {32'h0, 16'h0022});

    // Push and pop together at one entry: new entry becomes head.
    in_valid = 1'b1; in_instr = 16'h8004; in_pc = 16'h0030; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pushpop_valid_ready", {46'h0, out_valid, in_ready}, 48'h3);
    check("pushpop_head", {32'h0, out_opcode, out_instr}, {32'h0, 16'h8004});
    check("pushpop_immop", {45'h0, out_ImmOp}, {45'h0, 3'b011});

    // Flush at two entries beats a simultaneous push and pop.
    in_valid = 1'b1; in_instr = 16'h0123; in_pc = 16'h0032;
    step();
    check("refill_in_ready", {47'h0, in_ready}, 48'h0);
    in_instr = 16'h7777; in_pc = 16'h0034; flush = 1'b1; out_ready = 1'b1;
    step();
    idle_inputs();
    check("flush_valid_ready", {46'h0, out_valid, in_ready}, 48'h1);
    step();
    check("flush_nothing_pushed", {47'h0, out_valid}, 48'h0);

    // Stream 8 instructions under random backpressure.
    record_pops = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = 16'($urandom);
      in_pc    = 16'(2 * i);
      done = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
        out_ready = 1'($urandom_range(0, 1));
        acc = in_ready;
        step();
        if (acc) done = 1'b1;
      end
      check("stream_accept", {47'h0, done}, 48'h1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && out_valid; t++) step();
    out_ready = 1'b0;
    step();
    record_pops = 1'b0;
    check("stream_count", 48'(popped_pcs.size()), 48'd8);
    for (int i = 0; i < 8 && i < popped_pcs.size(); i++) begin
      check("stream_order_pc", {32'h0, popped_pcs[i]}, 48'(2 * i));
    end

    // Random traffic with occasional flushes.
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_instr  = 16'($urandom);
      in_pc     = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Asynchronous reset with two entries held.
    in_valid = 1'b1; in_instr = 16'h4321; in_pc = 16'h0050;
    step();
    in_instr = 16'hF00F; in_pc = 16'h0052;
    step();
    in_valid = 1'b0;
    check("pre_rst_full", {46'h0, out_valid, in_ready}, 48'h2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid_ready", {46'h0, out_valid, in_ready}, 48'h0);
    check("async_rst_outputs", {12'h0, out_opcode, out_instr, out_ImmOp, out_uses_imm, out_pc}, 48'h0);
    step();
    rst = 1'b0;
    step();
    in_valid = 1'b1; in_instr = 16'hC001; in_pc = 16'h0040;
    step();
    in_valid = 1'b0;
    check("post_rst_push_valid", {47'h0, out_valid}, 48'h1);
    check("post_rst_push_decode", {44'h0, out_ImmOp, out_uses_imm}, {44'h0, 4'b001_1});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_rst_pop_empty", {47'h0, out_valid}, 48'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
